// File: rtl/enc_8b10b_pkg.sv
// Shared 8b/10b constants: disparity encoding, K28.5 codes and the valid control-symbol list.
package enc_8b10b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    localparam int unsigned NUM_VALID_K = 12;

    // K28.0..K28.7, K23.7, K27.7, K29.7, K30.7
    localparam logic [7:0] VALID_K [NUM_VALID_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_valid_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_VALID_K; i++) begin
            if (b == VALID_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/enc_8b10b_stage.sv
// Combinational 8b/10b encoder: one byte (or control symbol) at a given running disparity.
module enc_8b10b_stage
    import enc_8b10b_pkg::*;
(
    input  logic [7:0] code_8b,
    input  logic       is_k,
    input  logic       disp,
    output logic [9:0] code_10b,
    output logic       disp_next,
    output logic       code_err
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k28;
    logic [5:0] s6_n;      // abcdei, a at MSB, RD- column
    logic [5:0] s6;
    logic [3:0] s4_n;      // fghj, f at MSB, RD- column
    logic [3:0] s4;
    logic       bal6;
    logic       bal4;
    logic       flip4;
    logic       disp_mid;

    assign x = code_8b[4:0];
    assign y = code_8b[7:5];

    // Pick the 5b/6b sub-block and derive the mid-symbol disparity.
    always_comb begin
        k_ok     = is_k && is_valid_k(code_8b);
        code_err = is_k && !k_ok;
        k28      = k_ok && (x == 5'd28);
        s6_n     = 6'b000000;
        if (k28) begin
            s6_n = 6'b001111;
        end else begin
            case (x)
                5'd0:  s6_n = 6'b100111;  5'd1:  s6_n = 6'b011101;
                5'd2:  s6_n = 6'b101101;  5'd3:  s6_n = 6'b110001;
                5'd4:  s6_n = 6'b110101;  5'd5:  s6_n = 6'b101001;
                5'd6:  s6_n = 6'b011001;  5'd7:  s6_n = 6'b111000;
                5'd8:  s6_n = 6'b111001;  5'd9:  s6_n = 6'b100101;
                5'd10: s6_n = 6'b010101;  5'd11: s6_n = 6'b110100;
                5'd12: s6_n = 6'b001101;  5'd13: s6_n = 6'b101100;
                5'd14: s6_n = 6'b011100;  5'd15: s6_n = 6'b010111;
                5'd16: s6_n = 6'b011011;  5'd17: s6_n = 6'b100011;
                5'd18: s6_n = 6'b010011;  5'd19: s6_n = 6'b110010;
                5'd20: s6_n = 6'b001011;  5'd21: s6_n = 6'b101010;
                5'd22: s6_n = 6'b011010;  5'd23: s6_n = 6'b111010;
                5'd24: s6_n = 6'b110011;  5'd25: s6_n = 6'b100110;
                5'd26: s6_n = 6'b010110;  5'd27: s6_n = 6'b110110;
                5'd28: s6_n = 6'b001110;  5'd29: s6_n = 6'b101110;
                5'd30: s6_n = 6'b011110;  default: s6_n = 6'b101011;
            endcase
        end
        bal6     = ($countones(s6_n) == 3);
        // D.7 is balanced but still has a distinct RD+ form.
        s6       = (disp && (!bal6 || (x == 5'd7 && !k28))) ? ~s6_n : s6_n;
        disp_mid = bal6 ? disp : ~disp;
    end

    // Pick the 3b/4b sub-block, applying the alternate A7 form where required.
    always_comb begin
        s4_n  = 4'b0000;
        flip4 = 1'b1;
        if (k_ok) begin
            case (y)
                3'd0: s4_n = 4'b1011;  3'd1: s4_n = 4'b0110;
                3'd2: s4_n = 4'b1010;  3'd3: s4_n = 4'b1100;
                3'd4: s4_n = 4'b1101;  3'd5: s4_n = 4'b0101;
                3'd6: s4_n = 4'b1001;  default: s4_n = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0: s4_n = 4'b1011;  3'd1: s4_n = 4'b1001;
                3'd2: s4_n = 4'b0101;  3'd3: s4_n = 4'b1100;
                3'd4: s4_n = 4'b1101;  3'd5: s4_n = 4'b1010;
                3'd6: s4_n = 4'b0110;
                default: begin
                    if ((!disp_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                        ( disp_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)))
                        s4_n = 4'b0111;
                    else
                        s4_n = 4'b1110;
                end
            endcase
            flip4 = ($countones(s4_n) != 2) || (y == 3'd3);
        end
        bal4      = ($countones(s4_n) == 2);
        s4        = (disp_mid && flip4) ? ~s4_n : s4_n;
        disp_next = bal4 ? disp_mid : ~disp_mid;
    end

    assign code_10b = {s4[0], s4[1], s4[2], s4[3],
                       s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};

endmodule

// File: rtl/axi4s_enc_8b10b.sv
// AXI4-Stream 8b/10b encoder: one registered output slot, running disparity, optional K28.5 idle fill.
module axi4s_enc_8b10b
    import enc_8b10b_pkg::*;
#(
    parameter bit IDLE_INSERT = 1'b0
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic [7:0] s_tdata,
    input  logic       s_tuser,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [9:0] m_tdata,
    output logic [1:0] m_tuser,
    input  logic       restart
);

    logic       rd_q,       rd_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic [9:0] m_tdata_q,  m_tdata_d;
    logic [1:0] m_tuser_q,  m_tuser_d;

    logic       slot_free;
    logic       accept;
    logic       idle_load;
    logic [7:0] enc_byte;
    logic       enc_k;
    logic       enc_disp;
    logic [9:0] enc_code;
    logic       enc_disp_next;
    logic       enc_err;

    assign slot_free = !m_tvalid_q || m_tready;
    assign accept    = s_tvalid && slot_free;
    assign idle_load = IDLE_INSERT && !s_tvalid && slot_free;

    // The idle path reuses the same encoder with K28.5 as its input.
    assign enc_byte = s_tvalid ? s_tdata : K28_5;
    assign enc_k    = s_tvalid ? s_tuser : 1'b1;
    assign enc_disp = restart ? RD_NEG : rd_q;

    enc_8b10b_stage u_stage (
        .code_8b   (enc_byte),
        .is_k      (enc_k),
        .disp      (enc_disp),
        .code_10b  (enc_code),
        .disp_next (enc_disp_next),
        .code_err  (enc_err)
    );

    // Load a new code when the slot is free, otherwise drain or hold.
    always_comb begin
        rd_d       = rd_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        if (accept || idle_load) begin
            rd_d       = enc_disp_next;
            m_tvalid_d = 1'b1;
            m_tdata_d  = enc_code;
            m_tuser_d  = {idle_load, enc_err && accept};
        end else begin
            if (m_tready) m_tvalid_d = 1'b0;
            if (restart)  rd_d       = RD_NEG;
        end
    end

    // Disparity and output slot registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q       <= RD_NEG;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 10'd0;
            m_tuser_q  <= 2'd0;
        end else begin
            rd_q       <= rd_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    assign s_tready = slot_free;
    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_axi4s_enc_8b10b.sv
// Bench for axi4s_enc_8b10b: directed steps plus random traffic, both IDLE_INSERT settings.
module tb_axi4s_enc_8b10b;

    localparam logic [9:0] KRDN = 10'h17C;
    localparam logic [9:0] KRDP = 10'h283;

    // 5b/6b tables written abcdei (a first), both disparity columns.
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    // 3b/4b tables written fghj (f first), indexed by y.
    localparam logic [3:0] T4DN [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4DP [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] T4KN [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] T4KP [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] VK [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                       8'hF7, 8'hFB, 8'hFD, 8'hFE};
    localparam bit IDLE_EN [2] = '{1'b0, 1'b1};

    logic       aclk = 1'b0;
    logic       aresetn = 1'b1;
    logic       s_tvalid [2];
    logic       s_tready [2];
    logic [7:0] s_tdata  [2];
    logic       s_tuser  [2];
    logic       m_tvalid [2];
    logic       m_tready [2];
    logic [9:0] m_tdata  [2];
    logic [1:0] m_tuser  [2];
    logic       restart  [2];

    int checks = 0;
    int failures = 0;

    // Reference state per instance.
    logic       ev  [2];
    logic [9:0] ed  [2];
    logic [1:0] eu  [2];
    logic       mrd [2];

    always #5 aclk = ~aclk;

    axi4s_enc_8b10b #(.IDLE_INSERT(1'b0)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]), .s_tuser(s_tuser[0]),
        .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]), .m_tuser(m_tuser[0]),
        .restart(restart[0]));

    axi4s_enc_8b10b #(.IDLE_INSERT(1'b1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]), .s_tuser(s_tuser[1]),
        .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]), .m_tuser(m_tuser[1]),
        .restart(restart[1]));

    // Returns {code_err, ending RD, code}; ending RD follows from the ones count of the symbol.
    function automatic logic [11:0] enc_model(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       valid;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rdm;
        logic [9:0] code;
        int         n;
        x = b[4:0];
        y = b[7:5];
        valid = k && ((x == 5'd28) || (y == 3'd7 && (x inside {5'd23, 5'd27, 5'd29, 5'd30})));
        if (valid && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
        else                     s6 = rd ? T6P[x] : T6N[x];
        n   = $countones(s6);
        rdm = (n > 3) ? 1'b1 : (n < 3) ? 1'b0 : rd;
        if (valid)
            s4 = rdm ? T4KP[y] : T4KN[y];
        else if (y == 3'd7 && ((!rdm && (x inside {5'd17, 5'd18, 5'd20})) ||
                               ( rdm && (x inside {5'd11, 5'd13, 5'd14}))))
            s4 = rdm ? 4'b1000 : 4'b0111;
        else
            s4 = rdm ? T4DP[y] : T4DN[y];
        code = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
        n = $countones(code);
        return {k && !valid, (n > 5) ? 1'b1 : (n < 5) ? 1'b0 : rd, code};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check s_tready, advance the reference, clock, check outputs.
    task automatic tick();
        logic        rdy;
        logic [11:0] r;
        #1;
        for (int u = 0; u < 2; u++) begin
            rdy = !ev[u] || m_tready[u];
            chk($sformatf("s_tready%0d", u), 10'(s_tready[u]), 10'(rdy));
            if (!aresetn) begin
                ev[u] = 1'b0; ed[u] = 10'd0; eu[u] = 2'd0; mrd[u] = 1'b0;
            end else if (s_tvalid[u] && rdy) begin
                r = enc_model(s_tdata[u], s_tuser[u], restart[u] ? 1'b0 : mrd[u]);
                ev[u] = 1'b1; ed[u] = r[9:0]; eu[u] = {1'b0, r[11]}; mrd[u] = r[10];
            end else if (IDLE_EN[u] && !s_tvalid[u] && rdy) begin
                r = enc_model(8'hBC, 1'b1, restart[u] ? 1'b0 : mrd[u]);
                ev[u] = 1'b1; ed[u] = r[9:0]; eu[u] = 2'b10; mrd[u] = r[10];
            end else begin
                if (m_tready[u]) ev[u] = 1'b0;
                if (restart[u])  mrd[u] = 1'b0;
            end
        end
        @(posedge aclk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("m_tvalid%0d", u), 10'(m_tvalid[u]), 10'(ev[u]));
            if (ev[u] || !aresetn) begin
                chk($sformatf("m_tdata%0d", u), m_tdata[u], ed[u]);
                chk($sformatf("m_tuser%0d", u), 10'(m_tuser[u]), 10'(eu[u]));
            end
        end
    endtask

    task automatic put0(input logic [7:0] d, input logic k, input logic rs);
        s_tvalid[0] = 1'b1; s_tdata[0] = d; s_tuser[0] = k; restart[0] = rs;
        tick();
        s_tvalid[0] = 1'b0; restart[0] = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        aresetn = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            ev[u] = 1'b0; ed[u] = 10'd0; eu[u] = 2'd0; mrd[u] = 1'b0;
            chk($sformatf("rst_valid%0d", u), 10'(m_tvalid[u]), 10'd0);
            chk($sformatf("rst_data%0d", u), m_tdata[u], 10'd0);
            chk($sformatf("rst_user%0d", u), 10'(m_tuser[u]), 10'd0);
        end
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        logic        p;
        logic [11:0] r;
        for (int u = 0; u < 2; u++) begin
            s_tvalid[u] = 1'b0; s_tdata[u] = 8'h00; s_tuser[u] = 1'b0;
            m_tready[u] = 1'b0; restart[u] = 1'b0;
            ev[u] = 1'b0; ed[u] = 10'd0; eu[u] = 2'd0; mrd[u] = 1'b0;
        end

        // Reset with a beat offered: nothing may load, s_tready stays high.
        s_tvalid[0] = 1'b1; s_tdata[0] = 8'h55;
        async_reset();
        chk("rst_sready", 10'(s_tready[0]), 10'd1);
        s_tvalid[0] = 1'b0;
        m_tready[0] = 1'b1;

        // D0.0 from RD-.
        put0(8'h00, 1'b0, 1'b0);
        chk("d00_code", m_tdata[0], 10'h0B9);
        chk("d00_user", 10'(m_tuser[0]), 10'd0);

        // Back-to-back K28.5 alternates, proving RD stayed RD- after D0.0.
        for (int i = 0; i < 4; i++) begin
            put0(8'hBC, 1'b1, 1'b0);
            chk("k285_alt", m_tdata[0], (i % 2 == 0) ? KRDN : KRDP);
            chk("k285_sready", 10'(s_tready[0]), 10'd1);
        end

        // Invalid control request K1.0 falls back to D1.0 with code_err.
        r = enc_model(8'h01, 1'b0, mrd[0]);
        put0(8'h01, 1'b1, 1'b0);
        chk("badk_err", 10'(m_tuser[0][0]), 10'd1);
        chk("badk_code", m_tdata[0], r[9:0]);

        // Backpressure: first beat held 5 cycles, second beat follows on release.
        put0(8'h5A, 1'b0, 1'b0);
        r = enc_model(8'h5A, 1'b0, 1'b0);
        s_tvalid[0] = 1'b1; s_tdata[0] = 8'hA5; s_tuser[0] = 1'b0; m_tready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", m_tdata[0], ed[0]);
            chk("bp_sready", 10'(s_tready[0]), 10'd0);
        end
        m_tready[0] = 1'b1;
        r = enc_model(8'hA5, 1'b0, mrd[0]);
        tick();
        chk("bp_order", m_tdata[0], r[9:0]);
        s_tvalid[0] = 1'b0;

        // Restart without an accept, then after a K28.5 left RD+.
        tick();
        restart[0] = 1'b1;
        tick();
        restart[0] = 1'b0;
        put0(8'hBC, 1'b1, 1'b0);
        chk("rst_k_a", m_tdata[0], KRDN);
        tick();
        restart[0] = 1'b1;
        tick();
        restart[0] = 1'b0;
        put0(8'hBC, 1'b1, 1'b0);
        chk("restart_idle", m_tdata[0], KRDN);
        // Restart in the same cycle as an accept.
        put0(8'hBC, 1'b1, 1'b1);
        chk("restart_accept", m_tdata[0], KRDN);

        // Reset while a beat is held, then first beat encodes from RD-.
        m_tready[0] = 1'b0;
        put0(8'h3C, 1'b1, 1'b0);
        async_reset();
        m_tready[0] = 1'b1;
        put0(8'hBC, 1'b1, 1'b0);
        chk("post_rst_k", m_tdata[0], KRDN);

        // Idle insertion: the held first idle is 17C, then alternation continues.
        m_tready[1] = 1'b1;
        p = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_code", m_tdata[1], p ? KRDP : KRDN);
            chk("idle_user", 10'(m_tuser[1]), 10'd2);
            p = ~p;
        end
        s_tvalid[1] = 1'b1; s_tdata[1] = 8'h00; s_tuser[1] = 1'b0;
        r = enc_model(8'h00, 1'b0, mrd[1]);
        tick();
        chk("idle_data_code", m_tdata[1], r[9:0]);
        chk("idle_data_user", 10'(m_tuser[1]), 10'd0);
        s_tvalid[1] = 1'b0;
        tick();
        chk("idle_resume", 10'(m_tuser[1]), 10'd2);

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int u = 0; u < 2; u++) begin
                s_tvalid[u] = ($urandom_range(3) != 0);
                m_tready[u] = ($urandom_range(9) < 7);
                s_tuser[u]  = ($urandom_range(5) == 0);
                if (s_tuser[u] && $urandom_range(1) == 1)
                    s_tdata[u] = VK[$urandom_range(11)];
                else
                    s_tdata[u] = 8'($urandom_range(255));
                restart[u] = (u == 0) && ($urandom_range(19) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
